noc_output_port_arbiter: RTL
============================

// Module: noc_output_port_arbiter
// PURPOSE
//  Round-robin arbiter and one-entry output register for a single mesh-router output port.
//  Up to five input ports request the output: LOCAL, EAST, NORTH, WEST and SOUTH.
//  The block picks one packet per cycle, registers it and presents it downstream on a valid/ready handshake.
//  One instance sits per router output, between the input buffers and the link or local PE.
// PARAMETERS
//  PACKET_LENGTH  27  packet width in bits: 1 + 2*COORD_LENGTH + max(DATA_WIDTH, ADDR_LENGTH)
//  N_PORTS        5   number of requesters; fixed at 5, in port-code order LOCAL..SOUTH
//  STALL_CNT_W    16  width of the backpressure stall counter
// PORTS
//  clk          in   1                      single clock; all state on rising edge
//  arst_n       in   1                      asynchronous active-low reset
//  req_i        in   N_PORTS                request bit per port; bit0 LOCAL, 1 EAST, 2 NORTH, 3 WEST, 4 SOUTH
//  pkt_i        in   N_PORTS*PACKET_LENGTH  packet of port p at [p*PACKET_LENGTH +: PACKET_LENGTH]
//  gnt_o        out  N_PORTS                one-hot grant; requester's packet is consumed this cycle
//  out_valid_o  out  1                      output register holds a packet
//  out_pkt_o    out  PACKET_LENGTH          registered packet
//  out_src_o    out  3                      port code of the source (LOCAL=0 .. SOUTH=4)
//  out_ready_i  in   1                      downstream accepts the packet this cycle
//  stall_cnt_o  out  STALL_CNT_W            saturating count of cycles with out_valid_o=1 and out_ready_i=0
// BEHAVIOUR
//  - Reset (async assert, sync deassert via clk): out_valid_o=0, out_pkt_o=0, out_src_o=0, stall_cnt_o=0.
//    Priority pointer is reset to LOCAL. gnt_o is forced to 0 while arst_n=0.
//  - load_en = !out_valid_o | out_ready_i. The register can accept a new packet when empty or draining this cycle.
//  - Arbitration (combinational):
//    - If load_en and req_i!=0, the winner is the first requesting port found scanning from the pointer
//      upward, wrapping SOUTH->LOCAL.
//    - gnt_o is the one-hot of the winner; otherwise gnt_o=0.
//  - On a grant: out_pkt_o <= winner's packet, out_src_o <= winner code, out_valid_o <= 1.
//    The pointer becomes (winner+1) mod 5.
//  - If load_en and req_i==0: out_valid_o <= 0. out_pkt_o and out_src_o hold their old values.
//  - If !load_en: all outputs and the pointer hold, and gnt_o=0.
//  - Latency: grant in cycle N, packet visible with out_valid_o=1 in cycle N+1.
//    Throughput is one packet per cycle while out_ready_i=1.
//  - Requester rules:
//    - A requester holds req_i and its packet stable until granted, and drops the request in the cycle after
//      the grant unless it has another packet.
//    - The arbiter never grants a deasserted request.
//  - Fairness: a continuously asserted request is granted within at most 5 grants.
//  - Downstream rules: out_pkt_o and out_src_o must stay stable while out_valid_o=1 and out_ready_i=0.
//    out_valid_o never drops without a transfer.
//  - Stall counter: increments by 1 each cycle with out_valid_o & !out_ready_i, and saturates at all-ones.
//    It is cleared only by reset.
//  - Reset mid-operation: any held packet is discarded with no grant issued. After reset the pointer is LOCAL.
//  - req_i bits with no valid port code cannot occur (N_PORTS is fixed at 5), so there is no X-handling.
// TESTING
//  T1 reset: drive arst_n=0 with req_i=5'b11111.
//     -> gnt_o=0, out_valid_o=0, stall_cnt_o=0.
//     After release with out_ready_i=1 -> the first grant is 5'b00001 (LOCAL).
//  T2 single request: req_i=5'b00010 (EAST), EAST pkt=27'h1234567, out_ready_i=1.
//     -> gnt_o=5'b00010 in cycle N.
//     -> cycle N+1: out_valid_o=1, out_pkt_o=27'h1234567, out_src_o=1.
//  T3 all request, ready=1 held for 7 cycles.
//     -> grants cycle through 00001,00010,00100,01000,10000,00001,00010.
//     -> out_valid_o stays 1 and out_src_o follows 0,1,2,3,4,0,1.
//  T4 backpressure: out_valid_o=1, out_ready_i=0 for 4 cycles with req_i=5'b00100.
//     -> gnt_o=0, out_pkt_o stable, stall_cnt_o=4.
//     Raising out_ready_i -> gnt_o=5'b00100 in that same cycle.
//  T5 pointer wrap: after a WEST grant, req_i=5'b10001 -> SOUTH granted first, then LOCAL.
//     Drain with req_i=0 and ready=1 -> out_valid_o=0 next cycle.
//  T6 reset mid-stream and saturation:
//     - Assert arst_n=0 while out_valid_o=1 -> out_valid_o=0 immediately (async).
//     - With STALL_CNT_W=4, hold out_ready_i=0 for 20 cycles -> stall_cnt_o stays at 4'hF.

Source files
------------

// File: rtl/noc_output_port_arbiter.sv
// Round-robin arbiter plus one-entry output register for a mesh-router output port.
// Grants one of five requesters per cycle and presents the packet on a valid/ready link.
module noc_output_port_arbiter #(
    parameter int unsigned PACKET_LENGTH = 27,
    parameter int unsigned N_PORTS       = 5,
    parameter int unsigned STALL_CNT_W   = 16
) (
    input  logic                               clk,
    input  logic                               arst_n,
    input  logic [N_PORTS-1:0]                 req_i,
    input  logic [N_PORTS*PACKET_LENGTH-1:0]   pkt_i,
    output logic [N_PORTS-1:0]                 gnt_o,
    output logic                               out_valid_o,
    output logic [PACKET_LENGTH-1:0]           out_pkt_o,
    output logic [2:0]                         out_src_o,
    input  logic                               out_ready_i,
    output logic [STALL_CNT_W-1:0]             stall_cnt_o
);

    localparam int unsigned SRC_W = 3;

    logic [SRC_W-1:0]         r_ptr;
    logic                     r_valid;
    logic [PACKET_LENGTH-1:0] r_pkt;
    logic [SRC_W-1:0]         r_src;
    logic [STALL_CNT_W-1:0]   r_stall;

    logic                     w_load_en;
    logic                     w_found;
    logic [SRC_W-1:0]         w_win;
    logic [N_PORTS-1:0]       w_gnt;
    logic [PACKET_LENGTH-1:0] w_pkt;
    logic [SRC_W-1:0]         w_ptr_nxt;

    assign w_load_en = !r_valid || out_ready_i;

    // First requester at or after the pointer, wrapping SOUTH back to LOCAL.
    always_comb begin
        int unsigned idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            idx = (32'(r_ptr) + 32'(k)) % N_PORTS;
            if (!w_found && req_i[idx]) begin
                w_found = 1'b1;
                w_win   = SRC_W'(idx);
            end
        end
    end

    // Grant is suppressed while reset is held so no packet is consumed then.
    always_comb begin
        w_gnt = '0;
        if (arst_n && w_load_en && w_found) begin
            w_gnt[w_win] = 1'b1;
        end
    end

    assign w_pkt     = pkt_i[32'(w_win)*PACKET_LENGTH +: PACKET_LENGTH];
    assign w_ptr_nxt = (w_win == SRC_W'(N_PORTS-1)) ? '0 : w_win + SRC_W'(1);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_pkt   <= '0;
            r_src   <= '0;
            r_stall <= '0;
        end else begin
            if (r_valid && !out_ready_i && (r_stall != '1)) begin
                r_stall <= r_stall + STALL_CNT_W'(1);
            end
            if (w_load_en) begin
                if (w_found) begin
                    r_valid <= 1'b1;
                    r_pkt   <= w_pkt;
                    r_src   <= w_win;
                    r_ptr   <= w_ptr_nxt;
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign gnt_o       = w_gnt;
    assign out_valid_o = r_valid;
    assign out_pkt_o   = r_pkt;
    assign out_src_o   = r_src;
    assign stall_cnt_o = r_stall;

endmodule
